executor_ula: RTL and testbench
===============================

Name: executor_ula

Overview:
- Sequencer between the control unit (UC) and the operand stack in the stack-based processor.
- On a UC request it pops one or two operands and computes the ALU result combinationally.
- It pushes the 32-bit result back through the stack's ALU data path (stack select = 1), then reports flags and done.
- It owns the stack's push, pop, select and ALU-data inputs while busy; the UC drives them only when ready is high.

Parameters:
- LARGURA, 16: operand width; matches the stack word width.
- LARGURA_ULA, 32: result width; matches the stack ALU data input.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  UC request; sampled only when ready=1
- opcode  in  4  operation; latched on accepted start
- ready  out  1  high only in IDLE
- done  out  1  one-cycle pulse; result pushed, flags valid
- err  out  1  one-cycle pulse; illegal opcode, no stack access
- flag_z  out  1  result[15:0]==0
- flag_n  out  1  result[15]
- flag_c  out  1  carry/borrow (ADD/SUB) or |result[31:16] (MUL); 0 otherwise
- pilha_pop  out  1  stack pop strobe
- pilha_push  out  1  stack push strobe
- pilha_sel  out  1  stack data select; 1 during PUSH, else 0
- pilha_dout  in  16  stack output; registered, valid the cycle after a pop
- resultado  out  32  to stack ALU data input; holds the last result

Behaviour:
- Operands: A = first pop (top of stack), B = second pop. Binary ops compute B op A.
- Opcodes:
  - 0 ADD, 1 SUB, 2 MUL (unsigned 16x16 -> 32), 3 AND, 4 OR, 5 XOR
  - 6 NOT, 7 NEG (two's complement): unary
  - 8 SHL: B << A[3:0]; 9 SHR: logical B >> A[3:0]
  - 10 EQ: 1 if B==A else 0; 11 LTS: 1 if signed B<A else 0
  - 12-15: illegal
- ADD/SUB: result = zero-extended 17-bit value; bit16 is carry for ADD, borrow for SUB.
- Other ops: result is zero-extended to 32 bits.
- FSM states: IDLE, POP_A, POP_B, CAP_A, EXEC, PUSH, ERR.
  - IDLE: start=1 with legal opcode -> latch opcode, go POP_A. Illegal opcode -> ERR. start=0 -> stay.
  - POP_A: pilha_pop=1. Binary -> POP_B; unary -> CAP_A.
  - POP_B: pilha_pop=1; capture A from pilha_dout -> EXEC.
  - CAP_A: capture A from pilha_dout -> EXEC.
  - EXEC: capture B (binary only) from pilha_dout. The combinational ALU output is registered into resultado and flag_* at the end of this cycle -> PUSH.
  - PUSH: pilha_push=1, pilha_sel=1, done=1 -> IDLE.
  - ERR: err=1 -> IDLE.
- Latency, start accepted at edge 0: binary op has done high in cycle 4 and ready high in cycle 5; unary op has done high in cycle 4 via POP_A, CAP_A, EXEC.
- EXEC is a single cycle for every op: MUL is combinational and registered once.
- pilha_push, pilha_pop, pilha_sel, done, err, ready are decoded from state only, so they are glitch-free.
- pop and push are never high in the same cycle.
- Stack underflow is the UC's responsibility; the block does not detect it.
- start while busy is ignored; no queuing.
- Reset (rst=0, asynchronous):
  - state = IDLE, ready=1
  - done, err, push, pop, sel = 0
  - resultado = 0; flag_z = 1, flag_n = 0, flag_c = 0
- Reset mid-operation aborts at once; push/pop deassert without waiting for a clock.
- resultado and flags keep their values until the next EXEC.

Decomposition:
- Package ula_pkg: opcode localparams (OP_ADD..OP_LTS), state encoding, is_unary/is_legal helper functions.
- One sub-module ula_comb: purely combinational, inputs (a, b, opcode), outputs result[31:0] and carry. Allows reuse and exhaustive unit test.
- The FSM, operand registers and flag logic stay in executor_ula.

Test Plan:
- Push 5 then 3; start, opcode=1 (SUB) -> pops in cycles 1-2, push in cycle 4 with resultado=2, done=1, flag_z=0, flag_c=0; stack top=2.
- Push 0xFFFF, 0x0002; MUL -> resultado=0x0001FFFE, flag_c=1; stack stores 0xFFFE, flag_n=1.
- Push 0x1234; NOT (6) -> exactly one pop; resultado=0xEDCB; done in cycle 4.
- Push 7, 7; EQ (10) -> resultado=1. Then push 0x8000, 1; LTS (11) -> resultado=1.
- start with opcode=13 -> err pulse in cycle 1, no push/pop at any time, ready back in cycle 2.
- Start ADD, drive rst=0 during POP_B -> pilha_pop low immediately; after release: ready=1, resultado=0, no push issued.

Source files
------------

// File: rtl/executor_ula_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states and opcode classifiers.
package ula_pkg;

    localparam int LARGURA     = 16;
    localparam int LARGURA_ULA = 32;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_NEG = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_EQ  = 4'd10;
    localparam logic [3:0] OP_LTS = 4'd11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP_A,
        ST_POP_B,
        ST_CAP_A,
        ST_EXEC,
        ST_PUSH,
        ST_ERR
    } estado_t;

    function automatic logic is_unary(input logic [3:0] op);
        return (op == OP_NOT) || (op == OP_NEG);
    endfunction

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_LTS;
    endfunction

endpackage

// File: rtl/executor_ula_if.sv
// Bus between the control unit / operand stack and the ALU sequencer.
interface executor_ula_if #(
    parameter int LARGURA     = 16,
    parameter int LARGURA_ULA = 32
) ();
    logic                   start;
    logic [3:0]             opcode;
    logic                   ready;
    logic                   done;
    logic                   err;
    logic                   flag_z;
    logic                   flag_n;
    logic                   flag_c;
    logic                   pilha_pop;
    logic                   pilha_push;
    logic                   pilha_sel;
    logic [LARGURA-1:0]     pilha_dout;
    logic [LARGURA_ULA-1:0] resultado;

    modport slave (
        input  start, opcode, pilha_dout,
        output ready, done, err, flag_z, flag_n, flag_c,
               pilha_pop, pilha_push, pilha_sel, resultado
    );

    modport master (
        output start, opcode, pilha_dout,
        input  ready, done, err, flag_z, flag_n, flag_c,
               pilha_pop, pilha_push, pilha_sel, resultado
    );
endinterface

// File: rtl/executor_ula_comb.sv
// Purely combinational ALU: computes B op A, zero-extended to the result width.
module ula_comb
    import ula_pkg::*;
#(
    parameter int LARGURA     = 16,
    parameter int LARGURA_ULA = 32
) (
    input  logic [LARGURA-1:0]     a,
    input  logic [LARGURA-1:0]     b,
    input  logic [3:0]             opcode,
    output logic [LARGURA_ULA-1:0] result,
    output logic                   carry
);
    localparam int SH = $clog2(LARGURA);

    logic [LARGURA:0]       soma;
    logic [LARGURA:0]       dif;
    logic [LARGURA_ULA-1:0] prod;
    logic [LARGURA-1:0]     nao;
    logic [LARGURA-1:0]     neg;
    logic [LARGURA-1:0]     shl;
    logic [LARGURA-1:0]     shr;

    // Narrow intermediates keep inversion/negation from leaking into the upper result bits.
    assign soma = {1'b0, b} + {1'b0, a};
    assign dif  = {1'b0, b} - {1'b0, a};
    assign prod = LARGURA_ULA'(b) * LARGURA_ULA'(a);
    assign nao  = ~a;
    assign neg  = -a;
    assign shl  = b << a[SH-1:0];
    assign shr  = b >> a[SH-1:0];

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (opcode)
            OP_ADD: begin result = LARGURA_ULA'(soma); carry = soma[LARGURA]; end
            OP_SUB: begin result = LARGURA_ULA'(dif);  carry = dif[LARGURA];  end
            OP_MUL: begin result = prod; carry = |prod[LARGURA_ULA-1:LARGURA]; end
            OP_AND: result = LARGURA_ULA'(b & a);
            OP_OR:  result = LARGURA_ULA'(b | a);
            OP_XOR: result = LARGURA_ULA'(b ^ a);
            OP_NOT: result = LARGURA_ULA'(nao);
            OP_NEG: result = LARGURA_ULA'(neg);
            OP_SHL: result = LARGURA_ULA'(shl);
            OP_SHR: result = LARGURA_ULA'(shr);
            OP_EQ:  result[0] = (b == a);
            OP_LTS: result[0] = ($signed(b) < $signed(a));
            default: ;
        endcase
    end
endmodule

// File: rtl/executor_ula.sv
// Sequencer that pops operands from the stack, runs the ALU and pushes the result back.
module executor_ula
    import ula_pkg::*;
#(
    parameter int LARGURA     = 16,
    parameter int LARGURA_ULA = 32
) (
    input  logic          clk,
    input  logic          rst,
    executor_ula_if.slave bus
);
    estado_t                state_reg;
    logic [3:0]             op_reg;
    logic [LARGURA-1:0]     a_reg;
    logic [LARGURA_ULA-1:0] resultado_reg;
    logic                   flag_z_reg;
    logic                   flag_n_reg;
    logic                   flag_c_reg;
    logic [LARGURA_ULA-1:0] alu_res;
    logic                   alu_carry;

    // B is taken straight from the stack output in EXEC, so no extra capture cycle is needed.
    ula_comb #(
        .LARGURA     (LARGURA),
        .LARGURA_ULA (LARGURA_ULA)
    ) u_ula (
        .a      (a_reg),
        .b      (bus.pilha_dout),
        .opcode (op_reg),
        .result (alu_res),
        .carry  (alu_carry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            op_reg        <= '0;
            a_reg         <= '0;
            resultado_reg <= '0;
            flag_z_reg    <= 1'b1;
            flag_n_reg    <= 1'b0;
            flag_c_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (is_legal(bus.opcode)) begin
                            op_reg    <= bus.opcode;
                            state_reg <= ST_POP_A;
                        end else begin
                            state_reg <= ST_ERR;
                        end
                    end
                end
                ST_POP_A: state_reg <= is_unary(op_reg) ? ST_CAP_A : ST_POP_B;
                ST_POP_B, ST_CAP_A: begin
                    a_reg     <= bus.pilha_dout;
                    state_reg <= ST_EXEC;
                end
                ST_EXEC: begin
                    resultado_reg <= alu_res;
                    flag_z_reg    <= (alu_res[LARGURA-1:0] == '0);
                    flag_n_reg    <= alu_res[LARGURA-1];
                    flag_c_reg    <= alu_carry;
                    state_reg     <= ST_PUSH;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready      = (state_reg == ST_IDLE);
    assign bus.pilha_pop  = (state_reg == ST_POP_A) || (state_reg == ST_POP_B);
    assign bus.pilha_push = (state_reg == ST_PUSH);
    assign bus.pilha_sel  = (state_reg == ST_PUSH);
    assign bus.done       = (state_reg == ST_PUSH);
    assign bus.err        = (state_reg == ST_ERR);
    assign bus.resultado  = resultado_reg;
    assign bus.flag_z     = flag_z_reg;
    assign bus.flag_n     = flag_n_reg;
    assign bus.flag_c     = flag_c_reg;
endmodule

// File: tb/tb_executor_ula.sv
// Self-checking bench: behavioural operand stack plus an arithmetic reference model of the ALU.
module tb_executor_ula;
    import ula_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    executor_ula_if bus ();

    executor_ula dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Operand stack as seen by the sequencer; the UC side can preload words with uc_push.
    logic [15:0] stk [0:255];
    int          sp = 0;
    int          pop_cnt = 0;
    int          push_cnt = 0;
    logic        uc_push = 1'b0;
    logic [15:0] uc_data = '0;

    always @(posedge clk) begin
        if (bus.pilha_pop) begin
            if (sp > 0) begin
                bus.pilha_dout <= stk[sp-1];
                sp <= sp - 1;
            end
            pop_cnt <= pop_cnt + 1;
        end else if (bus.pilha_push) begin
            stk[sp]  <= bus.pilha_sel ? bus.resultado[15:0] : uc_data;
            sp       <= sp + 1;
            push_cnt <= push_cnt + 1;
        end else if (uc_push) begin
            stk[sp] <= uc_data;
            sp      <= sp + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns {carry, result} computed from the opcode definitions with plain integer arithmetic.
    function automatic logic [32:0] ref_alu(input int op, input logic [15:0] a, input logic [15:0] b);
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint unsigned r  = 0;
        bit c = 0;
        case (op)
            0:  begin r = ub + ua; c = (r > 65535); end
            1:  begin c = (ub < ua); r = ((ub + 65536 - ua) % 65536) + (c ? 65536 : 0); end
            2:  begin r = ub * ua; c = (r > 65535); end
            3:  r = ub & ua;
            4:  r = ub | ua;
            5:  r = ub ^ ua;
            6:  r = 65535 - ua;
            7:  r = (65536 - ua) % 65536;
            8:  r = (ub << (ua % 16)) % 65536;
            9:  r = ub >> (ua % 16);
            10: r = (ub == ua) ? 1 : 0;
            11: r = ($signed(b) < $signed(a)) ? 1 : 0;
            default: r = 0;
        endcase
        return {c, r[31:0]};
    endfunction

    task automatic push_word(input logic [15:0] w);
        @(negedge clk);
        uc_data = w;
        uc_push = 1'b1;
        @(negedge clk);
        uc_push = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [15:0] b, input logic [15:0] a, input bit hold);
        bit          un;
        logic [32:0] e;
        int          p0, q0, done_cyc, ready_cyc;
        un = (op == 4'd6) || (op == 4'd7);
        if (!un) push_word(b);
        push_word(a);
        e = ref_alu(int'(op), a, b);
        @(negedge clk);
        check_val("ready_before", bus.ready, 1);
        p0 = pop_cnt;
        q0 = push_cnt;
        bus.start  = 1'b1;
        bus.opcode = op;
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
        done_cyc  = 0;
        ready_cyc = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (hold) bus.opcode = 4'($urandom_range(0, 15));
            if (bus.pilha_pop && bus.pilha_push) check_val("pop_push_overlap", 1, 0);
            if (bus.done) begin
                done_cyc = cyc;
                check_val("resultado", bus.resultado, e[31:0]);
                check_val("flag_z", bus.flag_z, (e[15:0] == 16'h0));
                check_val("flag_n", bus.flag_n, e[15]);
                check_val("flag_c", bus.flag_c, e[32]);
            end
            if (bus.ready) begin
                ready_cyc = cyc;
                bus.start = 1'b0;
                break;
            end
        end
        check_val("done_cycle", done_cyc, 4);
        check_val("ready_cycle", ready_cyc, 5);
        check_val("pop_count", pop_cnt - p0, un ? 1 : 2);
        check_val("push_count", push_cnt - q0, 1);
        check_val("stack_top", stk[sp-1], e[15:0]);
        $display("op=%0d b=%h a=%h resultado=%h z=%b n=%b c=%b", op, b, a, bus.resultado,
                 bus.flag_z, bus.flag_n, bus.flag_c);
    endtask

    task automatic run_err(input logic [3:0] op);
        int p0, q0, err_cyc, ready_cyc;
        logic [31:0] prev;
        @(negedge clk);
        p0 = pop_cnt;
        q0 = push_cnt;
        prev = bus.resultado;
        bus.start  = 1'b1;
        bus.opcode = op;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        err_cyc   = 0;
        ready_cyc = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (bus.pilha_pop || bus.pilha_push || bus.done) check_val("err_stack_access", 1, 0);
            if (bus.err) err_cyc = cyc;
            if (bus.ready) begin
                ready_cyc = cyc;
                break;
            end
        end
        check_val("err_cycle", err_cyc, 1);
        check_val("err_ready_cycle", ready_cyc, 2);
        check_val("err_pops", pop_cnt - p0, 0);
        check_val("err_pushes", push_cnt - q0, 0);
        check_val("err_resultado_hold", bus.resultado, prev);
        $display("illegal op=%0d err_cycle=%0d ready_cycle=%0d", op, err_cyc, ready_cyc);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.opcode = '0;
        #2 rst = 1'b0;
        #1;
        check_val("rst_ready", bus.ready, 1);
        check_val("rst_outputs", {bus.done, bus.err, bus.pilha_push, bus.pilha_pop, bus.pilha_sel}, 0);
        check_val("rst_resultado", bus.resultado, 0);
        check_val("rst_flags", {bus.flag_z, bus.flag_n, bus.flag_c}, 3'b100);
        $display("reset: ready=%b resultado=%h z=%b", bus.ready, bus.resultado, bus.flag_z);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        run_op(4'd1, 16'd5, 16'd3, 0);
        run_op(4'd2, 16'hFFFF, 16'h0002, 0);
        run_op(4'd6, 16'h0000, 16'h1234, 0);
        run_op(4'd10, 16'd7, 16'd7, 0);
        run_op(4'd11, 16'h8000, 16'h0001, 0);
        run_op(4'd0, 16'hFFFF, 16'h0001, 0);
        run_op(4'd7, 16'h0000, 16'h0000, 0);
        run_err(4'd13);
        for (int i = 12; i < 16; i++) run_err(4'(i));

        for (int i = 0; i < 40; i++) begin
            run_op(4'($urandom_range(0, 11)), 16'($urandom), 16'($urandom), bit'($urandom_range(0, 1)));
        end

        // Abort an ADD while it is popping B.
        begin
            int p0, q0;
            push_word(16'h0011);
            push_word(16'h0022);
            @(negedge clk);
            p0 = pop_cnt;
            q0 = push_cnt;
            bus.start  = 1'b1;
            bus.opcode = 4'd0;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            check_val("abort_in_pop_b", bus.pilha_pop, 1);
            rst = 1'b0;
            #1;
            check_val("abort_pop_low", bus.pilha_pop, 0);
            check_val("abort_ready", bus.ready, 1);
            repeat (2) @(negedge clk);
            rst = 1'b1;
            repeat (3) @(negedge clk);
            check_val("abort_ready_after", bus.ready, 1);
            check_val("abort_resultado", bus.resultado, 0);
            check_val("abort_flag_z", bus.flag_z, 1);
            check_val("abort_no_push", push_cnt - q0, 0);
            check_val("abort_pops", pop_cnt - p0, 1);
            $display("abort: ready=%b resultado=%h pushes=%0d", bus.ready, bus.resultado, push_cnt - q0);
        end

        run_op(4'd3, 16'hF0F0, 16'h3C3C, 0);
        run_op(4'd8, 16'h0001, 16'h001F, 0);
        run_op(4'd9, 16'h8000, 16'h000F, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
